// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the two-master arbiter.
// Transfer types, master IDs and the grant state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  typedef enum logic {
    GNT_CPU = M_CPU,
    GNT_DMA = M_DMA
  } gnt_e;

endpackage

// File: rtl/ahb_hold_counter.sv
// Saturating count of consecutive SEQ beats of the bus owner.
// at_limit tells the arbiter a burst may now lose the grant.
module ahb_hold_counter
  import ahb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] htrans,
  input  logic       hready,
  input  logic       owner_change,
  output logic       at_limit
);

  localparam logic [7:0] LIMIT = 8'(MAX_HOLD);

  logic [7:0] cnt;
  logic [7:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (hready) begin
      if (owner_change) begin
        cnt_nxt = '0;
      end else begin
        unique case (htrans_e'(htrans))
          SEQ:     cnt_nxt = (cnt >= LIMIT) ? LIMIT : cnt + 8'd1;
          BUSY:    cnt_nxt = cnt;
          default: cnt_nxt = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

  assign at_limit = (cnt >= LIMIT);

endmodule

// File: rtl/ahb_arbiter.sv
// Two-master AHB-Lite arbiter: round-robin with lock and
// burst protection, bursts capped at MAX_HOLD SEQ beats.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter logic        DEFAULT_MASTER = 1'b0,
  parameter int unsigned MAX_HOLD       = 16
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HBUSREQ_M0,
  input  logic       HBUSREQ_M1,
  input  logic       HLOCK_M0,
  input  logic       HLOCK_M1,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       HGRANT_M0,
  output logic       HGRANT_M1,
  output logic       HMASTER,
  output logic       HMASTLOCK
);

  localparam gnt_e GNT_DEF = gnt_e'(DEFAULT_MASTER);

  gnt_e    state;
  gnt_e    state_nxt;
  htrans_e trans;
  logic    gnt;
  logic    req_gnt;
  logic    lock_gnt;
  logic    at_limit;
  logic    owner_change;
  logic    lock_hold;
  logic    burst_hold;

  assign trans    = htrans_e'(HTRANS);
  assign gnt      = logic'(state);
  assign req_gnt  = gnt ? HBUSREQ_M1 : HBUSREQ_M0;
  assign lock_gnt = gnt ? HLOCK_M1 : HLOCK_M0;

  assign owner_change = HREADY && (gnt != HMASTER);

  ahb_hold_counter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold (
    .clk          (HCLK),
    .rst          (HRESET),
    .htrans       (HTRANS),
    .hready       (HREADY),
    .owner_change (owner_change),
    .at_limit     (at_limit)
  );

  // A locked sequence wins over the MAX_HOLD cap.
  assign lock_hold  = lock_gnt && req_gnt;
  assign burst_hold = (trans == SEQ || trans == BUSY)
                   && !at_limit && (gnt == HMASTER);

  always_comb begin
    state_nxt = state;
    if (HREADY && !lock_hold && !burst_hold) begin
      unique case ({HBUSREQ_M1, HBUSREQ_M0})
        2'b11:   state_nxt = gnt ? GNT_CPU : GNT_DMA;
        2'b01:   state_nxt = GNT_CPU;
        2'b10:   state_nxt = GNT_DMA;
        default: state_nxt = GNT_DEF;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= GNT_DEF;
    else        state <= state_nxt;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HMASTER   <= DEFAULT_MASTER;
      HMASTLOCK <= 1'b0;
    end else if (HREADY) begin
      HMASTER   <= gnt;
      HMASTLOCK <= lock_gnt;
    end
  end

  assign HGRANT_M0 = (state == GNT_CPU);
  assign HGRANT_M1 = (state == GNT_DMA);

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: vector table, corner sequences,
// and random traffic against a rule-level reference model.
module tb_ahb_arbiter;
  import ahb_pkg::*;

  localparam int MAXH = 4;
  localparam int DEFM = 0;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic       HBUSREQ_M0 = 1'b0;
  logic       HBUSREQ_M1 = 1'b0;
  logic       HLOCK_M0 = 1'b0;
  logic       HLOCK_M1 = 1'b0;
  logic [1:0] HTRANS = 2'b00;
  logic       HREADY = 1'b1;
  logic       HGRANT_M0;
  logic       HGRANT_M1;
  logic       HMASTER;
  logic       HMASTLOCK;

  int total = 0;
  int passed = 0;

  int mg, mm, ml, mc;

  always #5 HCLK = ~HCLK;

  ahb_arbiter #(
    .DEFAULT_MASTER (1'b0),
    .MAX_HOLD       (MAXH)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HBUSREQ_M0 (HBUSREQ_M0),
    .HBUSREQ_M1 (HBUSREQ_M1),
    .HLOCK_M0   (HLOCK_M0),
    .HLOCK_M1   (HLOCK_M1),
    .HTRANS     (HTRANS),
    .HREADY     (HREADY),
    .HGRANT_M0  (HGRANT_M0),
    .HGRANT_M1  (HGRANT_M1),
    .HMASTER    (HMASTER),
    .HMASTLOCK  (HMASTLOCK)
  );

  typedef struct {
    logic       r, q0, q1, l0, l1;
    logic [1:0] tr;
    logic       rdy;
    logic       g0, g1, m, lk;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: arbitration rules applied to the sampled inputs.
  task automatic model_step();
    int req[2];
    int lk[2];
    int ng;
    bit hold;
    req[0] = int'(HBUSREQ_M0);
    req[1] = int'(HBUSREQ_M1);
    lk[0]  = int'(HLOCK_M0);
    lk[1]  = int'(HLOCK_M1);
    if (HRESET) begin
      mg = DEFM; mm = DEFM; ml = 0; mc = 0;
    end else if (HREADY) begin
      hold = (lk[mg] == 1 && req[mg] == 1)
          || ((HTRANS == SEQ || HTRANS == BUSY)
              && mc < MAXH && mg == mm);
      if (hold)                            ng = mg;
      else if (req[0] == 1 && req[1] == 1) ng = 1 - mg;
      else if (req[0] == 1)                ng = 0;
      else if (req[1] == 1)                ng = 1;
      else                                 ng = DEFM;
      if (mg != mm)                        mc = 0;
      else if (HTRANS == SEQ)              mc = (mc + 1 > MAXH) ? MAXH : mc + 1;
      else if (HTRANS != BUSY)             mc = 0;
      mm = mg;
      ml = lk[mg];
      mg = ng;
    end
  endtask

  task automatic step(input logic r, input logic q0, input logic q1,
                      input logic l0, input logic l1,
                      input logic [1:0] tr, input logic rdy);
    @(negedge HCLK);
    HRESET = r; HBUSREQ_M0 = q0; HBUSREQ_M1 = q1;
    HLOCK_M0 = l0; HLOCK_M1 = l1; HTRANS = tr; HREADY = rdy;
    @(posedge HCLK);
    model_step();
    #1;
  endtask

  task automatic chk_model(input string name);
    chk({name, " grant0"}, int'(HGRANT_M0), int'(mg == 0));
    chk({name, " grant1"}, int'(HGRANT_M1), int'(mg == 1));
    chk({name, " hmaster"}, int'(HMASTER), mm);
    chk({name, " hmastlock"}, int'(HMASTLOCK), ml);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, IDLE,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, IDLE,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, IDLE,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, IDLE,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, IDLE,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NONSEQ, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NONSEQ, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NONSEQ, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NONSEQ, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, NONSEQ, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, SEQ,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, IDLE,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    mg = DEFM; mm = DEFM; ml = 0; mc = 0;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r, tbl[i].q0, tbl[i].q1, tbl[i].l0, tbl[i].l1,
           tbl[i].tr, tbl[i].rdy);
      chk($sformatf("vec%0d grant0", i), int'(HGRANT_M0), int'(tbl[i].g0));
      chk($sformatf("vec%0d grant1", i), int'(HGRANT_M1), int'(tbl[i].g1));
      chk($sformatf("vec%0d hmaster", i), int'(HMASTER), int'(tbl[i].m));
      chk($sformatf("vec%0d hmastlock", i), int'(HMASTLOCK), int'(tbl[i].lk));
    end

    // INCR burst by M0 capped at MAXH SEQ beats.
    step(1, 0, 0, 0, 0, IDLE, 1);
    step(0, 1, 0, 0, 0, IDLE, 1);
    step(0, 1, 0, 0, 0, NONSEQ, 1);
    for (int i = 0; i < MAXH; i++) begin
      step(0, 1, 1, 0, 0, SEQ, 1);
      chk($sformatf("burst seq%0d grant0", i), int'(HGRANT_M0), 1);
      chk_model($sformatf("burst seq%0d", i));
    end
    step(0, 1, 1, 0, 0, SEQ, 1);
    chk("burst cap grant1", int'(HGRANT_M1), 1);
    chk_model("burst cap");

    // Locked burst of 20 SEQ beats ignores the cap.
    step(1, 0, 0, 0, 0, IDLE, 1);
    step(0, 1, 1, 1, 0, NONSEQ, 1);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, 1, 0, SEQ, 1);
      chk($sformatf("lock seq%0d grant0", i), int'(HGRANT_M0), 1);
      chk($sformatf("lock seq%0d hmastlock", i), int'(HMASTLOCK), 1);
    end
    step(0, 1, 1, 0, 0, SEQ, 1);
    chk("unlock grant1", int'(HGRANT_M1), 1);
    chk_model("unlock");

    // Reset in the middle of an M1 locked burst.
    step(1, 0, 0, 0, 0, IDLE, 1);
    step(0, 0, 1, 0, 1, IDLE, 1);
    step(0, 0, 1, 0, 1, NONSEQ, 1);
    step(0, 0, 1, 0, 1, SEQ, 1);
    chk("pre-reset hmaster", int'(HMASTER), 1);
    chk("pre-reset hmastlock", int'(HMASTLOCK), 1);
    step(1, 0, 1, 0, 1, SEQ, 0);
    chk("mid reset grant0", int'(HGRANT_M0), 1);
    chk("mid reset hmaster", int'(HMASTER), 0);
    chk("mid reset hmastlock", int'(HMASTLOCK), 0);
    step(0, 0, 1, 0, 0, IDLE, 1);
    chk("post reset grant1", int'(HGRANT_M1), 1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(logic'($urandom_range(0, 49) == 0),
           logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)),
           logic'($urandom_range(0, 3) != 0));
      chk_model($sformatf("rand%0d", i));
      chk($sformatf("rand%0d onehot", i),
          int'(HGRANT_M0) + int'(HGRANT_M1), 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
